// File: rtl/uart_rx_deframer.sv
// Packet deframer behind uart_rx: SOF, LEN, LEN payload bytes, CHK.
// Payload goes out on a valid/ready stream; each frame ends in one frm_done or frm_err pulse.
module uart_rx_deframer #(
    parameter int              DATA_WIDTH     = 8,
    parameter logic [7:0]      SOF_BYTE       = 8'h7E,
    parameter int              MAX_LEN        = 64,
    parameter int              TIMEOUT_CYCLES = 20000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_vld,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_pc_pass,
    output logic                  o_rdy,
    output logic                  m_vld,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_rdy,
    output logic                  frm_done,
    output logic                  frm_err,
    output logic [1:0]            err_code,
    output logic [1:0]            dbg_state
);

    // Handshakes: a byte moves on the input side when i_vld && o_rdy, and on the
    // payload side when m_vld && m_rdy, both at the rising clk edge.

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DATA_WIDTH-1:0] SOF   = DATA_WIDTH'(SOF_BYTE);
    localparam logic [DATA_WIDTH-1:0] MAXL  = DATA_WIDTH'(MAX_LEN);
    localparam logic [TW-1:0]         T_END = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ERR_CHK    = 2'd0;
    localparam logic [1:0] ERR_PARITY = 2'd1;
    localparam logic [1:0] ERR_TIME   = 2'd2;
    localparam logic [1:0] ERR_LEN    = 2'd3;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        LEN     = 2'd1,
        PAYLOAD = 2'd2,
        CHK     = 2'd3
    } state_t;

    state_t                state, n_state;
    logic [DATA_WIDTH-1:0] sum, n_sum;
    logic [DATA_WIDTH-1:0] count, n_count;
    logic [TW-1:0]         timer, n_timer;
    logic                  n_m_vld, n_m_last, n_done, n_err;
    logic [DATA_WIDTH-1:0] n_m_data;
    logic [1:0]            n_code;
    logic                  accept;

    assign o_rdy     = !(state == PAYLOAD && m_vld && !m_rdy);
    assign accept    = i_vld && o_rdy;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= HUNT;
            sum      <= '0;
            count    <= '0;
            timer    <= '0;
            m_vld    <= 1'b0;
            m_last   <= 1'b0;
            m_data   <= '0;
            frm_done <= 1'b0;
            frm_err  <= 1'b0;
            err_code <= '0;
        end else begin
            state    <= n_state;
            sum      <= n_sum;
            count    <= n_count;
            timer    <= n_timer;
            m_vld    <= n_m_vld;
            m_last   <= n_m_last;
            m_data   <= n_m_data;
            frm_done <= n_done;
            frm_err  <= n_err;
            err_code <= n_code;
        end
    end

    always_comb begin
        n_state  = state;
        n_sum    = sum;
        n_count  = count;
        n_timer  = '0;
        n_m_vld  = m_vld && !m_rdy;
        n_m_last = m_last && n_m_vld;
        n_m_data = m_data;
        n_done   = 1'b0;
        n_err    = 1'b0;
        n_code   = err_code;

        // Timer only runs while the frame is waiting on uart_rx, never while stalled downstream.
        if (state != HUNT && o_rdy) begin
            n_timer = timer + TW'(1);
            if (timer == T_END && !accept) begin
                n_state = HUNT;
                n_timer = '0;
                n_err   = 1'b1;
                n_code  = ERR_TIME;
            end
        end

        if (accept) begin
            n_timer = '0;
            if (state != HUNT && !i_pc_pass) begin
                n_state = HUNT;
                n_err   = 1'b1;
                n_code  = ERR_PARITY;
            end else begin
                case (state)
                    HUNT: begin
                        if (i_data == SOF && i_pc_pass) n_state = LEN;
                    end
                    LEN: begin
                        n_sum   = i_data;
                        n_count = i_data;
                        if (i_data > MAXL) begin
                            n_state = HUNT;
                            n_err   = 1'b1;
                            n_code  = ERR_LEN;
                        end else if (i_data == '0) begin
                            n_state = CHK;
                        end else begin
                            n_state = PAYLOAD;
                        end
                    end
                    PAYLOAD: begin
                        n_m_data = i_data;
                        n_m_vld  = 1'b1;
                        n_m_last = (count == DATA_WIDTH'(1));
                        n_sum    = sum + i_data;
                        n_count  = count - DATA_WIDTH'(1);
                        if (count == DATA_WIDTH'(1)) n_state = CHK;
                    end
                    CHK: begin
                        n_state = HUNT;
                        if (DATA_WIDTH'(sum + i_data) == '0) begin
                            n_done = 1'b1;
                        end else begin
                            n_err  = 1'b1;
                            n_code = ERR_CHK;
                        end
                    end
                    default: n_state = HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer: one task per scenario, inline checks, one summary line.
module tb_uart_rx_deframer;

  localparam int TO = 50;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_vld = 1'b0;
  logic [7:0] i_data = '0;
  logic       i_pc_pass = 1'b1;
  logic       o_rdy;
  logic       m_vld;
  logic [7:0] m_data;
  logic       m_last;
  logic       m_rdy = 1'b1;
  logic       frm_done;
  logic       frm_err;
  logic [1:0] err_code;
  logic [1:0] dbg_state;

  int vectors = 0;
  int errors = 0;

  uart_rx_deframer #(
    .DATA_WIDTH(8), .SOF_BYTE(8'h7E), .MAX_LEN(64), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst_n), .i_vld(i_vld), .i_data(i_data), .i_pc_pass(i_pc_pass),
    .o_rdy(o_rdy), .m_vld(m_vld), .m_data(m_data), .m_last(m_last), .m_rdy(m_rdy),
    .frm_done(frm_done), .frm_err(frm_err), .err_code(err_code), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // scoreboard: observed payload and status pulses, sampled mid-cycle
  logic [7:0] exp_q[$];
  logic       exp_last_q[$];
  logic [7:0] got_q[$];
  logic       got_last_q[$];
  int         done_cnt = 0;
  int         err_cnt = 0;
  int         both_cnt = 0;
  logic [1:0] last_code = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (m_vld && m_rdy) begin
        got_q.push_back(m_data);
        got_last_q.push_back(m_last);
      end
      if (frm_done) done_cnt++;
      if (frm_err) begin
        err_cnt++;
        last_code = err_code;
      end
      if (frm_done && frm_err) both_cnt++;
    end
  end

  // driver tasks
  task automatic clear_sb();
    exp_q.delete(); exp_last_q.delete(); got_q.delete(); got_last_q.delete();
    done_cnt = 0; err_cnt = 0; both_cnt = 0;
  endtask

  task automatic send(input logic [7:0] b, input logic pc);
    logic ok;
    int   budget;
    i_vld = 1'b1; i_data = b; i_pc_pass = pc;
    budget = 200;
    forever begin
      @(negedge clk);
      ok = o_rdy;
      @(posedge clk);
      #1;
      if (ok) break;
      budget--;
      if (budget == 0) begin
        vectors++; errors++;
        $display("FAIL send_timeout byte=%h: o_rdy stayed 0 for 200 cycles, required 1", b);
        break;
      end
    end
    i_vld = 1'b0; i_pc_pass = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input string name, input int exp_done, input int exp_err,
                             input logic [1:0] exp_code);
    vectors++;
    if (got_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL %s_count: got %0d payload bytes, required %0d", name, got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        vectors++;
        if (got_q[i] !== exp_q[i] || got_last_q[i] !== exp_last_q[i]) begin
          errors++;
          $display("FAIL %s_byte%0d: got %h/last=%b, required %h/last=%b", name, i,
                   got_q[i], got_last_q[i], exp_q[i], exp_last_q[i]);
        end
      end
    end
    vectors++;
    if (done_cnt !== exp_done) begin
      errors++;
      $display("FAIL %s_done: got %0d pulses, required %0d", name, done_cnt, exp_done);
    end
    vectors++;
    if (err_cnt !== exp_err) begin
      errors++;
      $display("FAIL %s_err: got %0d pulses, required %0d", name, err_cnt, exp_err);
    end
    if (exp_err > 0) begin
      vectors++;
      if (last_code !== exp_code) begin
        errors++;
        $display("FAIL %s_code: got %0d, required %0d", name, last_code, exp_code);
      end
    end
    vectors++;
    if (both_cnt !== 0) begin
      errors++;
      $display("FAIL %s_overlap: done and err high together %0d times, required 0", name, both_cnt);
    end
  endtask

  task automatic push_exp(input logic [7:0] b, input logic last);
    exp_q.push_back(b);
    exp_last_q.push_back(last);
  endtask

  // scenarios
  task automatic test_reset();
    idle(3);
    vectors++;
    if ({m_vld, m_last, frm_done, frm_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b, required 0000", {m_vld, m_last, frm_done, frm_err});
    end
    vectors++;
    if (m_data !== 8'h00 || err_code !== 2'd0) begin
      errors++;
      $display("FAIL reset_values: got m_data=%h err_code=%0d, required 00/0", m_data, err_code);
    end
    vectors++;
    if (dbg_state !== 2'd0 || o_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got state=%0d o_rdy=%b, required 0/1", dbg_state, o_rdy);
    end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_good_frame();
    clear_sb();
    send(8'h7E, 1'b1); send(8'h03, 1'b1);
    send(8'h11, 1'b1);
    vectors++;
    if (m_vld !== 1'b1 || m_data !== 8'h11 || m_last !== 1'b0) begin
      errors++;
      $display("FAIL good_latency: got vld=%b data=%h last=%b, required 1/11/0", m_vld, m_data, m_last);
    end
    send(8'h22, 1'b1); send(8'h33, 1'b1); send(8'h97, 1'b1);
    vectors++;
    if (frm_done !== 1'b1) begin
      errors++;
      $display("FAIL good_done_timing: got frm_done=%b one cycle after CHK, required 1", frm_done);
    end
    idle(3);
    push_exp(8'h11, 0); push_exp(8'h22, 0); push_exp(8'h33, 1);
    check_frame("good", 1, 0, 2'd0);
  endtask

  task automatic test_bad_checksum();
    clear_sb();
    send(8'h7E, 1'b1); send(8'h03, 1'b1);
    send(8'h11, 1'b1); send(8'h22, 1'b1); send(8'h33, 1'b1); send(8'h98, 1'b1);
    idle(3);
    push_exp(8'h11, 0); push_exp(8'h22, 0); push_exp(8'h33, 1);
    check_frame("badchk", 0, 1, 2'd0);
  endtask

  task automatic test_zero_len();
    clear_sb();
    send(8'h7E, 1'b0);
    send(8'h55, 1'b1); send(8'h7E, 1'b1); send(8'h00, 1'b1); send(8'h00, 1'b1);
    idle(3);
    check_frame("zerolen", 1, 0, 2'd0);
  endtask

  task automatic test_parity();
    clear_sb();
    send(8'h7E, 1'b1); send(8'h02, 1'b1); send(8'hAA, 1'b0);
    idle(3);
    check_frame("parity", 0, 1, 2'd1);
    clear_sb();
    send(8'h7E, 1'b1); send(8'h01, 1'b1); send(8'h5A, 1'b1); send(8'hA5, 1'b1);
    idle(3);
    push_exp(8'h5A, 1);
    check_frame("after_parity", 1, 0, 2'd0);
  endtask

  task automatic test_length();
    logic [7:0] s;
    clear_sb();
    send(8'h7E, 1'b1); send(8'h41, 1'b1);
    idle(3);
    check_frame("len65", 0, 1, 2'd3);
    // MAX_LEN itself is accepted
    clear_sb();
    s = 8'h40;
    send(8'h7E, 1'b1); send(8'h40, 1'b1);
    for (int i = 0; i < 64; i++) begin
      send(8'(i * 3 + 1), 1'b1);
      s = s + 8'(i * 3 + 1);
      push_exp(8'(i * 3 + 1), i == 63);
    end
    send(8'(8'h00 - s), 1'b1);
    idle(3);
    check_frame("len64", 1, 0, 2'd0);
  endtask

  task automatic test_timeout();
    int n;
    clear_sb();
    send(8'h7E, 1'b1); send(8'h02, 1'b1); send(8'h01, 1'b1);
    n = 0;
    while (n < TO + 20) begin
      @(posedge clk);
      #1;
      n++;
      if (frm_err) break;
    end
    vectors++;
    if (n !== TO) begin
      errors++;
      $display("FAIL timeout_cycles: frm_err after %0d cycles, required %0d", n, TO);
    end
    vectors++;
    if (dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL timeout_hunt: got state %0d, required 0", dbg_state);
    end
    idle(2);
    push_exp(8'h01, 0);
    check_frame("timeout", 0, 1, 2'd2);
  endtask

  task automatic test_stall();
    clear_sb();
    send(8'h7E, 1'b1); send(8'h03, 1'b1); send(8'h11, 1'b1);
    m_rdy = 1'b0;
    fork
      begin
        send(8'h22, 1'b1); send(8'h33, 1'b1); send(8'h97, 1'b1);
      end
      begin
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          vectors++;
          if (o_rdy !== 1'b0) begin
            errors++;
            $display("FAIL stall_ordy cycle %0d: got o_rdy=%b, required 0", i, o_rdy);
          end
        end
        @(posedge clk);
        #1;
        m_rdy = 1'b1;
      end
    join
    idle(3);
    push_exp(8'h11, 0); push_exp(8'h22, 0); push_exp(8'h33, 1);
    check_frame("stall", 1, 0, 2'd0);
  endtask

  task automatic test_reset_mid();
    clear_sb();
    send(8'h7E, 1'b1); send(8'h03, 1'b1);
    m_rdy = 1'b0;
    send(8'h11, 1'b1);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({m_vld, m_last, frm_done, frm_err} !== 4'b0000 || m_data !== 8'h00) begin
      errors++;
      $display("FAIL midreset_outputs: got flags=%b data=%h, required 0000/00",
               {m_vld, m_last, frm_done, frm_err}, m_data);
    end
    vectors++;
    if (dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL midreset_state: got %0d, required 0", dbg_state);
    end
    m_rdy = 1'b1;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    clear_sb();
    send(8'h22, 1'b1); send(8'h7E, 1'b1); send(8'h01, 1'b1); send(8'h5A, 1'b1); send(8'hA5, 1'b1);
    idle(3);
    push_exp(8'h5A, 1);
    check_frame("after_reset", 1, 0, 2'd0);
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_zero_len();
    test_parity();
    test_length();
    test_timeout();
    test_stall();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
- Sits directly downstream of uart_rx and consumes its byte stream (vld/data/pc_pass, with i_rdy driven back).
- Recognises frames of the form SOF, LEN, LEN payload bytes, CHK.
- Forwards payload bytes on a valid/ready stream with a last marker, then reports per-frame done or error status.
- Gives the UART receive path packet semantics for downstream command/register logic.

Parameters:
- DATA_WIDTH, 8: byte width; must match uart_rx DATA_WIDTH.
- SOF_BYTE, 8'h7E: start-of-frame value, truncated to DATA_WIDTH.
- MAX_LEN, 64: largest accepted LEN; must be < 2**DATA_WIDTH.
- TIMEOUT_CYCLES, 20000: maximum idle clk cycles between bytes inside a frame.

Ports:
- clk  in  1  block clock.
- rst  in  1  reset, asynchronous, active-low.
- i_vld  in  1  byte valid from uart_rx o_vld.
- i_data  in  DATA_WIDTH  byte from uart_rx o_data.
- i_pc_pass  in  1  parity ok from uart_rx pc_pass; sampled with i_vld.
- o_rdy  out  1  drives uart_rx i_rdy.
- m_vld  out  1  payload byte valid.
- m_data  out  DATA_WIDTH  payload byte.
- m_last  out  1  final payload byte of frame; qualified by m_vld.
- m_rdy  in  1  downstream accepts payload.
- frm_done  out  1  one-cycle pulse: frame ended with correct checksum.
- frm_err  out  1  one-cycle pulse: frame aborted or bad.
- err_code  out  2  0 = checksum, 1 = parity, 2 = timeout, 3 = length > MAX_LEN; valid with frm_err, held until next frm_err.

Behaviour:
- Reset (rst low, async): state HUNT; m_vld, m_last, frm_done, frm_err = 0; err_code, m_data, sum, count, timer = 0.
- Byte accepted when i_vld && o_rdy. o_rdy = 1 except in PAYLOAD while m_vld && !m_rdy.
- States:
  - HUNT: discard accepted bytes unless byte == SOF_BYTE with i_pc_pass=1, then go to LEN. Parity errors in HUNT are silently dropped.
  - LEN: on accept, sum <= byte, count <= byte.
    - byte > MAX_LEN -> err 3, HUNT.
    - byte == 0 -> CHK.
    - else -> PAYLOAD.
  - PAYLOAD: on accept, m_data <= byte, m_vld <= 1, m_last <= (count == 1), sum <= sum + byte (mod 2**DATA_WIDTH), count-1. Go to CHK after the last byte. m_vld clears on m_rdy unless a new byte loads the same cycle; simultaneous m_rdy and load keeps m_vld = 1.
  - CHK: on accept, if (sum + byte) mod 2**DATA_WIDTH == 0, pulse frm_done, else err 0. Go to HUNT.
- Parity: any accepted byte with i_pc_pass=0 in LEN/PAYLOAD/CHK -> err 1, HUNT. A bad payload byte is not forwarded.
- Timeout: timer clears on every accept and on entry to LEN. It increments each cycle while state != HUNT and o_rdy = 1. At timer == TIMEOUT_CYCLES-1 -> err 2, HUNT. A timeout and an accept in the same cycle: the accept wins.
- Error in PAYLOAD: a byte already in the m_ register still completes its handshake; m_last is never asserted for an aborted frame. Downstream uses frm_err to discard the partial payload.
- frm_done/frm_err are registered, 1 cycle after the CHK/erroring accept, and never both high.
- SOF_BYTE inside LEN/PAYLOAD/CHK is ordinary data; there is no resync.
- Latency: payload byte appears on m_ 1 cycle after accept.

Test Plan:
- Frame 7E 03 11 22 33 97 (sum 0x69 + 0x97 = 0x100) with m_rdy=1 -> m_data 11, 22, 33; m_last only on 33; one frm_done pulse 1 cycle after 97; frm_err stays 0.
- Same frame with CHK = 0x98 -> three payload bytes forwarded, frm_err with err_code 0, no frm_done.
- Bytes 55 7E 00 00 -> 55 ignored; zero-length frame gives frm_done, no m_vld.
- 7E 02 AA with pc_pass=0 on AA -> frm_err err_code 1, AA not forwarded. Next 7E 01 5A A5 -> frm_done.
- 7E 41 with MAX_LEN=64 -> frm_err err_code 3. 7E 02 01, then idle TIMEOUT_CYCLES -> frm_err err_code 2, back to HUNT.
- Frame 7E 03 11 22 33 97 with m_rdy low for 10 cycles after first byte -> o_rdy low while stalled; no timeout fires; all bytes delivered in order; frm_done. Assert rst mid-frame -> outputs 0 immediately, HUNT.
